// File: rtl/sweep_pkg.sv
// Shared definitions for the stepped-frequency sweep controller: state encoding and default widths.
package sweep_pkg;

    localparam int FW_DEF = 32;
    localparam int NW_DEF = 16;
    localparam int SW_DEF = 24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts enabled cycles from a clear, flags when the count equals the target.
module dwell_timer
    import sweep_pkg::*;
#(
    parameter int SW = SW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [SW-1:0] target_i,
    output logic          hit_o
);

    logic [SW-1:0] count_q;
    logic [SW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit_o = (count_q == target_i);

endmodule

// File: rtl/sweep_ctrl.sv
// Stepped-frequency sweep sequencer driving the DDS tuning word and the capture request.
// Optional macro SWEEP_LOOP_EN adds loop_en: restart from fre_start after the last point.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int FW = FW_DEF,
    parameter int NW = NW_DEF,
    parameter int SW = SW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [FW-1:0] fre_start,
    input  logic [FW-1:0] fre_step,
    input  logic [NW-1:0] step_num,
    input  logic [SW-1:0] settle_cycles,
    input  logic          cap_done,
`ifdef SWEEP_LOOP_EN
    input  logic          loop_en,
`endif
    output logic          cap_req,
    output logic [FW-1:0] fre_k,
    output logic [NW-1:0] step_idx,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [FW-1:0] fre_k_q, fre_k_d;
    logic [NW-1:0] step_idx_q, step_idx_d;
    logic [FW-1:0] step_q, step_d;
    logic [NW-1:0] num_q, num_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          settle_hit;
    logic          is_last;
    logic          abort_go;

    assign is_last  = (step_idx_q == (num_q - 1'b1));
    assign abort_go = abort && (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort wins over every other event in a busy state, including cap_done.
    always_comb begin
        state_d = state_q;
        if (abort_go) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (start) state_d = ST_LOAD;
                ST_LOAD:    state_d = (step_num == '0) ? ST_DONE : ST_SETTLE;
                ST_SETTLE:  if (settle_hit) state_d = ST_CAPTURE;
                ST_CAPTURE: begin
                    if (cap_done) begin
                        if (is_last) begin
`ifdef SWEEP_LOOP_EN
                            state_d = loop_en ? ST_LOAD : ST_DONE;
`else
                            state_d = ST_DONE;
`endif
                        end else begin
                            state_d = ST_NEXT;
                        end
                    end
                end
                ST_NEXT:    state_d = ST_SETTLE;
                ST_DONE:    state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state_q != ST_IDLE);
        cap_req = (state_q == ST_CAPTURE);
        done    = (state_q == ST_DONE);
    end

    // Sweep configuration is captured only in LOAD; fre_k/step_idx hold through IDLE.
    always_comb begin
        fre_k_d    = fre_k_q;
        step_idx_d = step_idx_q;
        step_d     = step_q;
        num_d      = num_q;
        settle_d   = settle_q;
        if (!abort_go) begin
            case (state_q)
                ST_LOAD: begin
                    fre_k_d    = fre_start;
                    step_idx_d = '0;
                    step_d     = fre_step;
                    num_d      = step_num;
                    settle_d   = settle_cycles;
                end
                ST_NEXT: begin
                    fre_k_d    = fre_k_q + step_q;
                    step_idx_d = step_idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fre_k_q    <= '0;
            step_idx_q <= '0;
            step_q     <= '0;
            num_q      <= '0;
            settle_q   <= '0;
        end else begin
            fre_k_q    <= fre_k_d;
            step_idx_q <= step_idx_d;
            step_q     <= step_d;
            num_q      <= num_d;
            settle_q   <= settle_d;
        end
    end

    dwell_timer #(.SW(SW)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    ((state_q == ST_LOAD) || (state_q == ST_NEXT)),
        .en_i     (state_q == ST_SETTLE),
        .target_i (settle_q),
        .hit_o    (settle_hit)
    );

    assign fre_k    = fre_k_q;
    assign step_idx = step_idx_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: directed and randomized sweeps against an arithmetic timing model.
module tb_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] fre_start;
    logic [31:0] fre_step;
    logic [15:0] step_num;
    logic [23:0] settle_cycles;
    logic        cap_done;
`ifdef SWEEP_LOOP_EN
    logic        loop_en;
`endif
    logic        cap_req;
    logic [31:0] fre_k;
    logic [15:0] step_idx;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    sweep_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .fre_start     (fre_start),
        .fre_step      (fre_step),
        .step_num      (step_num),
        .settle_cycles (settle_cycles),
        .cap_done      (cap_done),
`ifdef SWEEP_LOOP_EN
        .loop_en       (loop_en),
`endif
        .cap_req       (cap_req),
        .fre_k         (fre_k),
        .step_idx      (step_idx),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge; inputs set then apply to that cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for cap_req; optionally perturbs config inputs, start and cap_done while waiting.
    task automatic wait_capreq(input bit noise, output int rise);
        rise = -1;
        for (int k = 0; k < 3000; k++) begin
            tick();
            start    = 1'b0;
            cap_done = 1'b0;
            if (cap_req) begin
                rise = cyc;
                break;
            end
            if (noise) begin
                fre_step      = $urandom;
                step_num      = 16'($urandom_range(0, 20));
                settle_cycles = 24'($urandom_range(0, 30));
                fre_start     = $urandom;
                start         = ($urandom_range(0, 3) == 0);
                cap_done      = ($urandom_range(0, 3) == 0);
            end
        end
        if (rise < 0) chk("capreq_timeout", 32'd0, 32'd1);
    endtask

    // Model: point i plays fs + i*st (mod 2^32); cap_req rises 3+s cycles after start or after the previous cap_done.
    task automatic run_sweep(input logic [31:0] fs, input logic [31:0] st, input int n, input int s,
                             input int d, input int abort_pt, input bit do_start, input bit noise,
                             input bit loop_last);
        int t, r, c, base;
        logic [31:0] exp_f;
        logic [31:0] ii;
        if (do_start) begin
            fre_start     = fs;
            fre_step      = st;
            step_num      = 16'(n);
            settle_cycles = 24'(s);
            start         = 1'b1;
        end
        t = cyc;
        tick();
        start    = 1'b0;
        cap_done = 1'b0;
        chk("busy_T1", busy, 1);
        chk("capreq_T1", cap_req, 0);
        chk("done_T1", done, 0);
        if (n == 0) begin
            tick();
            chk("zero_done_T2", done, 1);
            chk("zero_busy_T2", busy, 1);
            chk("zero_capreq_T2", cap_req, 0);
            chk("zero_frek", fre_k, fs);
            tick();
            chk("zero_done_T3", done, 0);
            chk("zero_busy_T3", busy, 0);
            return;
        end
        tick();
        chk("frek_T2", fre_k, fs);
        chk("idx_T2", step_idx, 0);
        base = t;
        for (int i = 0; i < n; i++) begin
            wait_capreq(noise, r);
            if (r < 0) return;
            chk("capreq_time", r, base + 3 + s);
            ii    = i;
            exp_f = fs + st * ii;
            chk("frek_point", fre_k, exp_f);
            chk("idx_point", step_idx, ii);
            repeat (d) tick();
            chk("capreq_hold", cap_req, 1);
            cap_done = 1'b1;
            c = cyc;
            if (i == abort_pt) begin
                abort = 1'b1;
                start = 1'b1;
                tick();
                abort    = 1'b0;
                start    = 1'b0;
                cap_done = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_capreq", cap_req, 0);
                chk("abort_done", done, 0);
                chk("abort_idx", step_idx, ii);
                tick();
                chk("abort_done2", done, 0);
                chk("abort_busy2", busy, 0);
                return;
            end
            if (i == n - 1 && loop_last) return;
            tick();
            cap_done = 1'b0;
            chk("capreq_fall", cap_req, 0);
            if (i == n - 1) begin
                chk("end_done", done, 1);
                chk("end_busy", busy, 1);
                tick();
                chk("end_done_gone", done, 0);
                chk("end_idle", busy, 0);
                chk("end_frek_hold", fre_k, exp_f);
                chk("end_idx_hold", step_idx, ii);
            end else begin
                chk("mid_done", done, 0);
            end
            base = c;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        fre_start     = '0;
        fre_step      = '0;
        step_num      = '0;
        settle_cycles = '0;
        cap_done      = 1'b0;
`ifdef SWEEP_LOOP_EN
        loop_en       = 1'b0;
`endif
        #3;
        chk("rst_frek", fre_k, 0);
        chk("rst_idx", step_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_capreq", cap_req, 0);
        chk("rst_done", done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Abort while idle has no effect.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);

        run_sweep(32'd1000, 32'd500, 3, 4, 10, -1, 1'b1, 1'b0, 1'b0);
        tick();
        run_sweep(32'h1234_5678, 32'd7, 0, 3, 1, -1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("zero_no_capreq", cap_req, 0);
        run_sweep(32'hFFFF_FF00, 32'h200, 2, 2, 3, -1, 1'b1, 1'b0, 1'b0);
        tick();
        run_sweep(32'd5000, 32'd100, 3, 3, 4, 1, 1'b1, 1'b0, 1'b0);
        tick();
        run_sweep(32'd777, 32'd33, 3, 5, 2, -1, 1'b1, 1'b1, 1'b0);
        tick();
        run_sweep(32'd9, 32'd1, 2, 0, 1, -1, 1'b1, 1'b0, 1'b0);
        tick();

        for (int k = 0; k < 6; k++) begin
            run_sweep($urandom, $urandom, $urandom_range(1, 4), $urandom_range(0, 6),
                      $urandom_range(1, 5), -1, 1'b1, ($urandom_range(0, 1) == 1), 1'b0);
            repeat ($urandom_range(1, 3)) tick();
        end

`ifdef SWEEP_LOOP_EN
        loop_en = 1'b1;
        run_sweep(32'd2000, 32'd250, 2, 1, 2, -1, 1'b1, 1'b0, 1'b1);
        run_sweep(32'd2000, 32'd250, 2, 1, 2, -1, 1'b0, 1'b0, 1'b1);
        loop_en = 1'b0;
        run_sweep(32'd2000, 32'd250, 2, 1, 2, -1, 1'b0, 1'b0, 1'b0);
        tick();
`endif

        // Asynchronous reset in the middle of a sweep.
        fre_start     = 32'hABCD;
        fre_step      = 32'h10;
        step_num      = 16'd4;
        settle_cycles = 24'd8;
        start         = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_frek", fre_k, 0);
        chk("async_rst_idx", step_idx, 0);
        chk("async_rst_capreq", cap_req, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sweep_ctrl.md
Name: sweep_ctrl

Overview:
Sequences a stepped-frequency sweep of the DDS phase accumulator and the ADC capture path. It drives the tuning word `fre_k` from a latched start value in fixed increments. At each point it waits a settle time, then requests one ADC capture burst (the FIFO/UART path) and waits for its completion before stepping. It sits between the SPI register bank/key logic and `add_32bit` plus the capture front end, in the `sys_clk` domain.

Parameters:
- FW, 32, tuning-word width (`fre_start`, `fre_step`, `fre_k`).
- NW, 16, width of point count and point index.
- SW, 24, width of the settle-cycle count.

Ports:
- clk  in  1  system clock (`sys_clk`).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle sweep start request.
- abort  in  1  single-cycle abort request.
- fre_start  in  FW  first tuning word.
- fre_step  in  FW  tuning-word increment per point.
- step_num  in  NW  number of sweep points.
- settle_cycles  in  SW  clk cycles to wait after each frequency change.
- cap_done  in  1  single-cycle pulse: capture burst finished.
- cap_req  out  1  level: capture requested at the current point.
- fre_k  out  FW  tuning word to the phase accumulator.
- step_idx  out  NW  index of the current point.
- busy  out  1  high from LOAD through DONE inclusive.
- done  out  1  single-cycle pulse at sweep end.

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0.
- States: IDLE, LOAD, SETTLE, CAPTURE, NEXT, DONE.
- IDLE:
  - `start`=1 -> LOAD.
  - `start` while not in IDLE is ignored.
- LOAD (1 cycle):
  - Latch `fre_start`, `fre_step`, `step_num`, `settle_cycles`. Input changes after LOAD have no effect until the next sweep.
  - `fre_k` <= `fre_start`; `step_idx` <= 0; settle counter <= 0.
  - If `step_num`==0 -> DONE (no capture). Else -> SETTLE.
- SETTLE:
  - Counter increments each cycle.
  - Leave when counter == latched `settle_cycles` -> CAPTURE. `settle_cycles`=0 gives exactly 1 cycle in SETTLE.
- CAPTURE:
  - `cap_req`=1 while in this state.
  - On `cap_done`: `cap_req` falls next cycle. If `step_idx` == `step_num`-1 -> DONE, else -> NEXT.
  - `cap_done` in any other state is ignored.
- NEXT (1 cycle):
  - `fre_k` <= `fre_k` + `fre_step`, modulo 2^FW (wrap, no saturation).
  - `step_idx` <= `step_idx` + 1; settle counter <= 0; -> SETTLE.
- DONE (1 cycle): `done`=1 -> IDLE.
- Busy/hold:
  - `busy`=0 only in IDLE.
  - `fre_k` and `step_idx` hold their last values in IDLE, so the last frequency keeps playing.
- Abort:
  - `abort` in any non-IDLE state -> IDLE next cycle; `cap_req` deasserts next cycle; `done` not pulsed.
  - `abort` beats a simultaneous `cap_done` or `start`.
  - `abort` in IDLE: no effect.
- Latency:
  - `start` at cycle T: `busy` rises T+1, `fre_k` = `fre_start` at T+2.
  - First `cap_req` at T+3+`settle_cycles`.
- Asynchronous reset mid-sweep returns to reset values immediately.

Optional Feature:
- Macro: SWEEP_LOOP_EN.
- Defined: adds input port `loop_en` (1 bit). If `loop_en`=1 at the last point's `cap_done`, go to LOAD instead of DONE. LOAD re-latches inputs and restarts from `fre_start`; `done` is not pulsed. The sweep continues until `abort` or `loop_en`=0.
- Undefined: port absent; behaviour exactly as above.

Decomposition:
- Shared package `sweep_pkg`: state encoding constants (3-bit: IDLE=0, LOAD=1, SETTLE=2, CAPTURE=3, NEXT=4, DONE=5) and the default FW/NW/SW values.
- One natural sub-module, `dwell_timer`: SW-bit counter with clear and a `hit` output (count == target), instantiated for SETTLE.

Test Plan:
- Basic sweep: `fre_start`=1000, `fre_step`=500, `step_num`=3, `settle_cycles`=4, `cap_done` 10 cycles after each `cap_req` rise.
  - `fre_k` sequence 1000, 1500, 2000.
  - Three `cap_req` pulses, first at T+7.
  - `done` pulse after third `cap_done`; `fre_k` holds 2000.
- Zero points: `step_num`=0, `start` -> `busy` for 2 cycles, `done` at T+2, `cap_req` never high, `fre_k`=`fre_start`.
- Wrap-around: `fre_start`=32'hFFFF_FF00, `fre_step`=32'h200, `step_num`=2 -> second `fre_k`=32'h0000_0100.
- Abort with simultaneous `cap_done` in CAPTURE at point 1 -> IDLE next cycle, no `done`, `step_idx`=1, `cap_req`=0.
- Config change mid-sweep: change `fre_step` and `step_num` during SETTLE, plus `start` during busy -> sweep uses latched values, `start` ignored.
- SWEEP_LOOP_EN defined, `loop_en`=1, `step_num`=2 -> `fre_k` pattern repeats A, A+s, A, A+s, no `done`. Drop `loop_en` -> `done` after the next last point.
